// File: rtl/jstk_poll_if.sv
// jstk_poll_if: bundles the PmodJSTK transactor signals and the game/cursor-side outputs
//   master: led_req, jstk_ss, jstk_dout driven; snd_rec, jstk_din, x/y, buttons, status observed
//   slave : the poll controller side (inverse directions)
interface jstk_poll_if;
    logic [1:0]  led_req;
    logic        jstk_ss;
    logic [39:0] jstk_dout;
    logic        snd_rec;
    logic [7:0]  jstk_din;
    logic [9:0]  x_data;
    logic [9:0]  y_data;
    logic [1:0]  btn_level;
    logic        btn_set;
    logic        btn_rst;
    logic        sample_valid;
    logic        timeout_err;
    modport master (
        output led_req, jstk_ss, jstk_dout,
        input  snd_rec, jstk_din, x_data, y_data, btn_level, btn_set, btn_rst, sample_valid, timeout_err
    );
    modport slave (
        input  led_req, jstk_ss, jstk_dout,
        output snd_rec, jstk_din, x_data, y_data, btn_level, btn_set, btn_rst, sample_valid, timeout_err
    );
endinterface

// File: rtl/jstk_poll_ctrl.sv
// jstk_poll_ctrl: handshaked PmodJSTK poll scheduler with frame unpacking and button debounce
//   clk, rst     : 100 MHz clock, asynchronous active-high reset
//   jb.led_req   : requested {LED2,LED1}, copied into jstk_din while idle
//   jb.jstk_ss   : transactor SS monitor (low = transfer in progress)
//   jb.jstk_dout : 40-bit frame, latched when SS returns high
//   jb.snd_rec   : transfer request level (START/XFER)
//   jb.jstk_din  : command byte {6'b100000, led_req}
//   jb.x_data/y_data, btn_level, btn_set/btn_rst pulses, sample_valid pulse, sticky timeout_err
module jstk_poll_ctrl #(
    parameter int POLL_CYCLES = 20_000_000,
    parameter int START_TO    = 1_000,
    parameter int XFER_TO     = 2_000_000,
    parameter int DB_SAMPLES  = 2
) (
    input logic       clk,
    input logic       rst,
    jstk_poll_if.slave jb
);
    localparam int PW = $clog2(POLL_CYCLES) + 1;
    localparam int SW = $clog2(START_TO > XFER_TO ? START_TO : XFER_TO) + 1;
    localparam int DW = $clog2(DB_SAMPLES) + 1;

    typedef enum logic [2:0] {IDLE, START, XFER, CAPTURE, FAIL} state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        poll_q, poll_d;
    logic [SW-1:0]        to_q, to_d;
    logic [7:0]           din_q, din_d;
    logic [9:0]           x_q, x_d, y_q, y_d;
    logic [1:0]           lvl_q, lvl_d;
    logic [1:0][DW-1:0]   cnt_q, cnt_d;
    logic                 set_q, set_d, brst_q, brst_d, sv_q, sv_d, err_q, err_d;
    logic [1:0]           btn;
    logic                 unused_dout;

    assign btn         = {jb.jstk_dout[2], jb.jstk_dout[1]};
    assign unused_dout = ^{jb.jstk_dout[31:26], jb.jstk_dout[15:10], jb.jstk_dout[7:3], jb.jstk_dout[0]};

    always_comb begin
        state_d = state_q;
        // free-running poll timer keeps the period fixed regardless of transfer length
        poll_d  = (poll_q == '0) ? PW'(POLL_CYCLES - 1) : poll_q - 1'b1;
        to_d    = to_q + 1'b1;
        din_d   = (state_q == IDLE) ? {6'b100000, jb.led_req} : din_q;
        x_d     = x_q;
        y_d     = y_q;
        lvl_d   = lvl_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        sv_d    = (state_q == CAPTURE);
        case (state_q)
            IDLE: begin
                to_d = '0;
                if (poll_q == '0) state_d = START;
            end
            START: begin
                if (!jb.jstk_ss) begin
                    state_d = XFER;
                    to_d    = '0;
                end else if (to_q == SW'(START_TO - 1)) state_d = FAIL;
            end
            XFER: begin
                if (jb.jstk_ss) state_d = CAPTURE;
                else if (to_q == SW'(XFER_TO - 1)) state_d = FAIL;
            end
            CAPTURE: begin
                state_d = IDLE;
                x_d     = {jb.jstk_dout[9:8], jb.jstk_dout[23:16]};
                y_d     = {jb.jstk_dout[25:24], jb.jstk_dout[39:32]};
                // count consecutive frames disagreeing with the accepted level
                for (int i = 0; i < 2; i++) begin
                    if (btn[i] == lvl_q[i]) cnt_d[i] = '0;
                    else if (cnt_q[i] == DW'(DB_SAMPLES - 1)) begin
                        lvl_d[i] = btn[i];
                        cnt_d[i] = '0;
                    end else cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
            FAIL: begin
                state_d = IDLE;
                err_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        set_d  = ~lvl_q[0] & lvl_d[0];
        brst_d = ~lvl_q[1] & lvl_d[1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            poll_q  <= PW'(POLL_CYCLES - 1);
            to_q    <= '0;
            din_q   <= 8'h80;
            x_q     <= '0;
            y_q     <= '0;
            lvl_q   <= '0;
            cnt_q   <= '0;
            set_q   <= 1'b0;
            brst_q  <= 1'b0;
            sv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            poll_q  <= poll_d;
            to_q    <= to_d;
            din_q   <= din_d;
            x_q     <= x_d;
            y_q     <= y_d;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
            set_q   <= set_d;
            brst_q  <= brst_d;
            sv_q    <= sv_d;
            err_q   <= err_d;
        end
    end

    assign jb.snd_rec      = (state_q == START) || (state_q == XFER);
    assign jb.jstk_din     = din_q;
    assign jb.x_data       = x_q;
    assign jb.y_data       = y_q;
    assign jb.btn_level    = lvl_q;
    assign jb.btn_set      = set_q;
    assign jb.btn_rst      = brst_q;
    assign jb.sample_valid = sv_q;
    assign jb.timeout_err  = err_q;
endmodule

// File: tb/tb_jstk_poll_ctrl.sv
// tb_jstk_poll_ctrl: transaction-level reference model checked against jstk_poll_ctrl every cycle
module tb_jstk_poll_ctrl;
    localparam int PC = 100, STO = 8, XTO = 40, DB = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jstk_poll_if ifc();
    jstk_poll_ctrl #(.POLL_CYCLES(PC), .START_TO(STO), .XFER_TO(XTO), .DB_SAMPLES(DB))
        dut (.clk(clk), .rst(rst), .jb(ifc));

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    logic [1:0] led_s = 2'b00;

    // cycle index since reset release; cycle 0 is the interval in which rst falls
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;
    always @(posedge clk) led_s <= ifc.led_req;

    // scheduled poll: start cycle, SS low delay/length after start, frame presented
    int          cur_s = PC, cur_d = 255, cur_h = 1;
    logic [39:0] cur_frame = '0;

    // model state
    logic [9:0] mx, my;
    logic [1:0] mlvl, mold;
    int         mrun [2];
    logic       merr, e_sv, e_set, e_rst;

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // cycles snd_rec stays high: SS sampled low at the end of cycle d opens XFER
    function automatic int xlen(input int d, input int h);
        if (d >= STO) return STO;
        return (h <= XTO) ? d + h + 1 : d + XTO + 1;
    endfunction

    function automatic bit xok(input int d, input int h);
        return (d < STO) && (h <= XTO);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            mx = '0; my = '0; mlvl = '0; merr = 1'b0;
            mrun[0] = 0; mrun[1] = 0;
        end else begin
            e_sv = 1'b0;
            mold = mlvl;
            if (cyc == cur_s + xlen(cur_d, cur_h) + 1) begin
                if (xok(cur_d, cur_h)) begin
                    mx   = {cur_frame[9:8], cur_frame[23:16]};
                    my   = {cur_frame[25:24], cur_frame[39:32]};
                    e_sv = 1'b1;
                    for (int i = 0; i < 2; i++) begin
                        if (cur_frame[i+1] != mlvl[i]) begin
                            mrun[i]++;
                            if (mrun[i] >= DB) begin
                                mlvl[i] = cur_frame[i+1];
                                mrun[i] = 0;
                            end
                        end else mrun[i] = 0;
                    end
                end else merr = 1'b1;
            end
            e_set = mlvl[0] & ~mold[0];
            e_rst = mlvl[1] & ~mold[1];
            chk("snd_rec", ifc.snd_rec, (cyc >= cur_s) && (cyc < cur_s + xlen(cur_d, cur_h)));
            chk("jstk_din", ifc.jstk_din, {6'b100000, led_s});
            chk("x_data", ifc.x_data, mx);
            chk("y_data", ifc.y_data, my);
            chk("btn_level", ifc.btn_level, mlvl);
            chk("btn_set", ifc.btn_set, e_set);
            chk("btn_rst", ifc.btn_rst, e_rst);
            chk("sample_valid", ifc.sample_valid, e_sv);
            chk("timeout_err", ifc.timeout_err, merr);
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_poll(input int d, input int h, input logic [39:0] fr, input logic [1:0] led, input bit pin);
        cur_d = d;
        cur_h = h;
        cur_frame = fr;
        ifc.jstk_dout = fr;
        ifc.led_req = led;
        if (pin) begin
            wait_cyc(cur_s - 1);
            chk("pre_start_snd", ifc.snd_rec, 1'b0);
            wait_cyc(cur_s);
            chk("start_snd", ifc.snd_rec, 1'b1);
        end
        if (d != 255) begin
            wait_cyc(cur_s + d);
            ifc.jstk_ss = 1'b0;
            wait_cyc(cur_s + d + h);
            ifc.jstk_ss = 1'b1;
        end
        wait_cyc(cur_s + xlen(d, h) + 2);
        cur_s += PC;
    endtask

    function automatic logic [39:0] mkf(input logic b1, input logic b2);
        logic [39:0] f;
        f = {$urandom, $urandom};
        f[1] = b1;
        f[2] = b2;
        return f;
    endfunction

    initial begin
        ifc.led_req = 2'b00;
        ifc.jstk_ss = 1'b1;
        ifc.jstk_dout = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_snd", ifc.snd_rec, 1'b0);
        chk("rst_din", ifc.jstk_din, 8'h80);
        chk("rst_x", ifc.x_data, 10'h0);
        chk("rst_err", ifc.timeout_err, 1'b0);
        @(negedge clk);
        #1 rst = 1'b0;
        cur_s = PC;

        do_poll(3, 20, 40'h12_03_34_01_56, 2'b00, 1'b1);
        chk("t1_x", ifc.x_data, 10'h134);
        chk("t1_y", ifc.y_data, 10'h312);

        do_poll(3, 10, mkf(0, 0), 2'b01, 1'b1);
        do_poll(2, 12, mkf(1, 0), 2'b01, 1'b0);
        do_poll(2, 12, mkf(0, 0), 2'b01, 1'b0);
        do_poll(2, 12, mkf(1, 0), 2'b11, 1'b0);
        do_poll(2, 12, mkf(0, 0), 2'b11, 1'b0);
        chk("t3_level", ifc.btn_level, 2'b00);

        do_poll(1, 5, mkf(0, 0), 2'b00, 1'b0);
        do_poll(1, 5, mkf(1, 0), 2'b00, 1'b0);
        do_poll(1, 5, mkf(1, 0), 2'b00, 1'b0);
        chk("t2_level", ifc.btn_level, 2'b01);
        do_poll(1, 5, mkf(1, 0), 2'b00, 1'b0);

        do_poll(255, 1, mkf(0, 1), 2'b10, 1'b1);
        chk("t4_err", ifc.timeout_err, 1'b1);

        do_poll(2, 45, mkf(0, 1), 2'b10, 1'b0);
        do_poll(3, 15, mkf(0, 1), 2'b10, 1'b0);
        chk("t5_err_sticky", ifc.timeout_err, 1'b1);

        for (int k = 0; k < 14; k++)
            do_poll($urandom_range(0, 9), $urandom_range(1, 45), {$urandom, $urandom}, 2'($urandom), 1'b0);

        cur_d = 2; cur_h = 30;
        cur_frame = mkf(1, 1);
        ifc.jstk_dout = cur_frame;
        wait_cyc(cur_s + 7);
        rst = 1'b1;
        ifc.led_req = 2'b00;
        #1;
        chk("arst_snd", ifc.snd_rec, 1'b0);
        chk("arst_din", ifc.jstk_din, 8'h80);
        chk("arst_x", ifc.x_data, 10'h0);
        chk("arst_y", ifc.y_data, 10'h0);
        chk("arst_lvl", ifc.btn_level, 2'b00);
        chk("arst_err", ifc.timeout_err, 1'b0);
        ifc.jstk_ss = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        cur_s = PC;
        do_poll(3, 10, mkf(1, 1), 2'b10, 1'b1);
        chk("led_din", ifc.jstk_din, 8'h82);

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: run did not complete within time limit");
        $fatal(1);
    end
endmodule
